// File: rtl/ast_mem_arb_pkg.sv
// Shared types and the rotating-priority pick function for the system RAM arbiter.
package ast_mem_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam logic PRIO_FIXED = 1'b0;
    localparam logic PRIO_RR    = 1'b1;

    // The pick function works on a fixed 8-wide request vector; narrower
    // arbiters zero-extend into it.
    localparam int MAX_MASTERS = 8;
    localparam int PICK_W      = 3;

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] idx;
    } pick_t;

    // First asserted request at or after ptr, wrapping modulo num_masters.
    // Fixed priority is the same search started at index 0.
    function automatic pick_t rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input logic [PICK_W-1:0]      ptr,
        input int                     num_masters
    );
        pick_t res;
        int    j;
        res = '0;
        for (int k = 0; k < MAX_MASTERS; k++) begin
            j = (int'(ptr) + k) % num_masters;
            if (k < num_masters && !res.found && req[j[PICK_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = j[PICK_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ast_mem_arb_rdpipe_sv.sv
// Read-return tracker: carries {valid, master index} for DEPTH cycles so the
// response can be steered to the master that issued the read.
module ast_mem_arb_rdpipe_sv #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    input  logic [IDX_W-1:0] push_idx,
    output logic             pop_valid,
    output logic [IDX_W-1:0] pop_idx,
    output logic             any_valid
);

    logic [DEPTH-1:0]            stage_valid;
    logic [DEPTH-1:0][IDX_W-1:0] stage_idx;

    // NOTE: only the valid bits are reset; an index is don't-care while its valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid <= '0;
        end else begin
            stage_valid[0] <= push_valid;
            for (int i = 1; i < DEPTH; i++) begin
                stage_valid[i] <= stage_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        stage_idx[0] <= push_idx;
        for (int i = 1; i < DEPTH; i++) begin
            stage_idx[i] <= stage_idx[i-1];
        end
    end

    assign pop_valid = stage_valid[DEPTH-1];
    assign pop_idx   = stage_idx[DEPTH-1];
    assign any_valid = |stage_valid;

endmodule

// File: rtl/ast_mem_arbiter_sv.sv
// N-master arbiter for the single-port system RAM with fixed/round-robin
// priority, capped locked bursts, pipelined read return and a write snoop.
module ast_mem_arbiter_sv
    import ast_mem_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int DATAWIDTH   = 16,
    parameter int ADDRWIDTH   = 16,
    parameter int READ_LAT    = 1,
    parameter int LOCK_MAX    = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             prio_mode,
    input  logic [NUM_MASTERS-1:0]           req,
    input  logic [NUM_MASTERS-1:0]           wen,
    input  logic [NUM_MASTERS-1:0]           lock,
    input  logic [NUM_MASTERS*ADDRWIDTH-1:0] addr,
    input  logic [NUM_MASTERS*DATAWIDTH-1:0] wdata,
    output logic [NUM_MASTERS-1:0]           gnt,
    output logic [NUM_MASTERS-1:0]           rvalid,
    output logic [DATAWIDTH-1:0]             rdata,
    output logic [ADDRWIDTH-1:0]             ram_addr,
    output logic [DATAWIDTH-1:0]             ram_data,
    output logic                             ram_wren,
    input  logic [DATAWIDTH-1:0]             ram_q,
    output logic                             snoop_valid,
    output logic [ADDRWIDTH-1:0]             snoop_addr,
    output logic [DATAWIDTH-1:0]             snoop_data,
    output logic [$clog2(NUM_MASTERS)-1:0]   snoop_src,
    output logic                             busy
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_t       state, state_next;
    logic [IDX_W-1:0] owner, owner_next;
    logic [IDX_W-1:0] rr_ptr, ptr_next;
    logic [CNT_W-1:0] lock_cnt, cnt_next, cnt_inc;

    logic [MAX_MASTERS-1:0] req_ext;
    logic [PICK_W-1:0]      ptr_sel;
    pick_t                  pick;
    logic                   gnt_any;
    logic [IDX_W-1:0]       gnt_idx;

    logic [ADDRWIDTH-1:0] addr_hold;
    logic [DATAWIDTH-1:0] data_hold;

    logic             rd_push;
    logic             rd_pop;
    logic [IDX_W-1:0] rd_pop_idx;
    logic             rd_inflight;

    assign cnt_inc = lock_cnt + CNT_W'(1);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        owner_next = owner;
        cnt_next   = lock_cnt;
        ptr_next   = rr_ptr;
        gnt_any    = 1'b0;
        gnt_idx    = '0;

        req_ext                  = '0;
        req_ext[NUM_MASTERS-1:0] = req;
        ptr_sel                  = (prio_mode == PRIO_RR) ? PICK_W'(rr_ptr) : '0;
        pick                     = rr_pick(req_ext, ptr_sel, NUM_MASTERS);

        if (!reset) begin
            unique case (state)
                ARB: begin
                    if (pick.found) begin
                        gnt_any = 1'b1;
                        gnt_idx = IDX_W'(pick.idx);
                        if (int'(pick.idx) == NUM_MASTERS - 1) begin
                            ptr_next = '0;
                        end else begin
                            ptr_next = IDX_W'(pick.idx) + IDX_W'(1);
                        end
                        // A cap of one grant means a lock can never extend ownership.
                        if (lock[gnt_idx] && LOCK_MAX > 1) begin
                            owner_next = gnt_idx;
                            cnt_next   = CNT_W'(1);
                            state_next = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    gnt_idx = owner;
                    if (req[owner]) begin
                        gnt_any  = 1'b1;
                        cnt_next = cnt_inc;
                        if (!lock[owner] || cnt_inc == CNT_W'(LOCK_MAX)) begin
                            state_next = ARB;
                        end
                    end else begin
                        state_next = ARB;
                    end
                end
                default: state_next = ARB;
            endcase
        end
    end

    always_comb begin
        gnt = '0;
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // The RAM bus parks on the last granted access while idle.
    always_comb begin
        if (gnt_any) begin
            ram_addr = addr[int'(gnt_idx)*ADDRWIDTH +: ADDRWIDTH];
            ram_data = wdata[int'(gnt_idx)*DATAWIDTH +: DATAWIDTH];
        end else begin
            ram_addr = addr_hold;
            ram_data = data_hold;
        end
    end

    assign ram_wren = gnt_any & wen[gnt_idx];
    assign rd_push  = gnt_any & ~wen[gnt_idx];
    assign busy     = gnt_any | rd_inflight;

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB;
            owner    <= '0;
            lock_cnt <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            lock_cnt <= cnt_next;
            rr_ptr   <= ptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_hold   <= '0;
            data_hold   <= '0;
            rvalid      <= '0;
            rdata       <= '0;
            snoop_valid <= 1'b0;
            snoop_addr  <= '0;
            snoop_data  <= '0;
            snoop_src   <= '0;
        end else begin
            if (gnt_any) begin
                addr_hold <= ram_addr;
                data_hold <= ram_data;
            end

            rvalid <= '0;
            if (rd_pop) begin
                rvalid[rd_pop_idx] <= 1'b1;
                rdata              <= ram_q;
            end

            snoop_valid <= ram_wren;
            if (ram_wren) begin
                snoop_addr <= ram_addr;
                snoop_data <= ram_data;
                snoop_src  <= gnt_idx;
            end
        end
    end

    ast_mem_arb_rdpipe_sv #(
        .DEPTH (READ_LAT),
        .IDX_W (IDX_W)
    ) u_rdpipe (
        .clk        (clk),
        .reset      (reset),
        .push_valid (rd_push),
        .push_idx   (gnt_idx),
        .pop_valid  (rd_pop),
        .pop_idx    (rd_pop_idx),
        .any_valid  (rd_inflight)
    );

endmodule

// File: tb/tb_ast_mem_arbiter_sv.sv
// Directed bench for ast_mem_arbiter_sv: a 2-master/READ_LAT=1 instance with a
// read-response scoreboard, and a 4-master/READ_LAT=3 instance.
module tb_ast_mem_arbiter_sv;

    logic clk = 1'b0;
    logic reset;
    logic preload;

    always #5 clk = ~clk;

    // ---------------- instance A: 2 masters, READ_LAT=1, LOCK_MAX=4
    logic        a_prio;
    logic [1:0]  a_req, a_wen, a_lock, a_gnt, a_rvalid;
    logic [31:0] a_addr, a_wdata;
    logic [15:0] a_rdata, a_ram_addr, a_ram_data, a_ram_q, a_snoop_addr, a_snoop_data;
    logic        a_ram_wren, a_snoop_valid, a_busy;
    logic [0:0]  a_snoop_src;
    logic [15:0] mem_a [0:255];

    ast_mem_arbiter_sv #(
        .NUM_MASTERS(2), .DATAWIDTH(16), .ADDRWIDTH(16), .READ_LAT(1), .LOCK_MAX(4)
    ) dut_a (
        .clk(clk), .reset(reset), .prio_mode(a_prio), .req(a_req), .wen(a_wen),
        .lock(a_lock), .addr(a_addr), .wdata(a_wdata), .gnt(a_gnt), .rvalid(a_rvalid),
        .rdata(a_rdata), .ram_addr(a_ram_addr), .ram_data(a_ram_data),
        .ram_wren(a_ram_wren), .ram_q(a_ram_q), .snoop_valid(a_snoop_valid),
        .snoop_addr(a_snoop_addr), .snoop_data(a_snoop_data), .snoop_src(a_snoop_src),
        .busy(a_busy)
    );

    always @(posedge clk) begin
        if (preload) begin
            mem_a[8'h10] <= 16'hAAAA;
            mem_a[8'h20] <= 16'hBBBB;
        end else if (a_ram_wren) begin
            mem_a[a_ram_addr[7:0]] <= a_ram_data;
        end
        a_ram_q <= mem_a[a_ram_addr[7:0]];
    end

    // ---------------- instance B: 4 masters, READ_LAT=3
    logic        b_prio;
    logic [3:0]  b_req, b_wen, b_lock, b_gnt, b_rvalid;
    logic [63:0] b_addr, b_wdata;
    logic [15:0] b_rdata, b_ram_addr, b_ram_data, b_ram_q, b_snoop_addr, b_snoop_data;
    logic [15:0] b_q1, b_q2;
    logic        b_ram_wren, b_snoop_valid, b_busy;
    logic [1:0]  b_snoop_src;
    logic [15:0] mem_b [0:255];

    ast_mem_arbiter_sv #(
        .NUM_MASTERS(4), .DATAWIDTH(16), .ADDRWIDTH(16), .READ_LAT(3), .LOCK_MAX(4)
    ) dut_b (
        .clk(clk), .reset(reset), .prio_mode(b_prio), .req(b_req), .wen(b_wen),
        .lock(b_lock), .addr(b_addr), .wdata(b_wdata), .gnt(b_gnt), .rvalid(b_rvalid),
        .rdata(b_rdata), .ram_addr(b_ram_addr), .ram_data(b_ram_data),
        .ram_wren(b_ram_wren), .ram_q(b_ram_q), .snoop_valid(b_snoop_valid),
        .snoop_addr(b_snoop_addr), .snoop_data(b_snoop_data), .snoop_src(b_snoop_src),
        .busy(b_busy)
    );

    always @(posedge clk) begin
        if (preload) begin
            mem_b[8'h05] <= 16'h5A5A;
        end else if (b_ram_wren) begin
            mem_b[b_ram_addr[7:0]] <= b_ram_data;
        end
        b_q1    <= mem_b[b_ram_addr[7:0]];
        b_q2    <= b_q1;
        b_ram_q <= b_q2;
    end

    // ---------------- checking
    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        int          master;
        logic [15:0] data;
    } rd_exp_t;

    rd_exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instance A read grant this cycle: response due READ_LAT+1 = 2 cycles later.
    task automatic push_rd(input int master, input logic [15:0] data);
        rd_exp_t e;
        e.due    = cyc + 2;
        e.master = master;
        e.data   = data;
        sb.push_back(e);
    endtask

    task automatic sb_check();
        rd_exp_t    e;
        logic [1:0] ev;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e          = sb.pop_front();
            ev         = '0;
            ev[e.master] = 1'b1;
            check("a_rvalid", a_rvalid, ev);
            check("a_rdata", a_rdata, e.data);
        end else begin
            check("a_rvalid_idle", a_rvalid, 2'b00);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        sb_check();
    endtask

    initial begin
        reset   = 1'b1;
        preload = 1'b1;
        a_prio  = 1'b0; a_req = 2'b11; a_wen = '0; a_lock = '0; a_addr = '0; a_wdata = '0;
        b_prio  = 1'b0; b_req = 4'b1111; b_wen = '0; b_lock = '0; b_addr = '0; b_wdata = '0;

        // Reset: grants suppressed even with requests pending.
        repeat (3) tick();
        sample();
        check("rst_a_gnt", a_gnt, 2'b00);
        check("rst_a_busy", a_busy, 1'b0);
        check("rst_a_wren", a_ram_wren, 1'b0);
        check("rst_a_snoop", a_snoop_valid, 1'b0);
        check("rst_a_rdata", a_rdata, 16'h0);
        check("rst_b_gnt", b_gnt, 4'b0000);
        check("rst_b_rvalid", b_rvalid, 4'b0000);

        tick();
        reset = 1'b0; preload = 1'b0; a_req = '0; b_req = '0;
        sample();
        check("idle_a_busy", a_busy, 1'b0);
        check("idle_b_busy", b_busy, 1'b0);

        // Fixed priority, two reads.
        tick();
        a_prio = 1'b0; a_req = 2'b11; a_addr = {16'h0020, 16'h0010};
        sample();
        check("fix_gnt0", a_gnt, 2'b01);
        check("fix_addr0", a_ram_addr, 16'h0010);
        check("fix_wren0", a_ram_wren, 1'b0);
        push_rd(0, 16'hAAAA);
        tick();
        a_req = 2'b10;
        sample();
        check("fix_gnt1", a_gnt, 2'b10);
        check("fix_addr1", a_ram_addr, 16'h0020);
        push_rd(1, 16'hBBBB);
        tick();
        a_req = 2'b00;
        sample();
        check("fix_gnt_idle", a_gnt, 2'b00);
        check("fix_addr_hold", a_ram_addr, 16'h0020);
        check("fix_busy_inflight", a_busy, 1'b1);
        tick();
        sample();
        check("fix_busy_done", a_busy, 1'b0);

        // Round robin, both requesting for 6 cycles.
        for (int k = 0; k < 6; k++) begin
            tick();
            a_prio = 1'b1; a_req = 2'b11;
            sample();
            check("rr_gnt", a_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
            push_rd(k % 2, (k % 2 == 0) ? 16'hAAAA : 16'hBBBB);
        end
        tick(); a_req = 2'b00; sample();
        tick(); sample();

        // Master 1 locks: 4 grants, forced release, master 0 on the 5th.
        tick();
        a_req = 2'b10; a_lock = 2'b10;
        sample();
        check("lock_gnt0", a_gnt, 2'b10);
        push_rd(1, 16'hBBBB);
        for (int k = 1; k < 4; k++) begin
            tick();
            a_req = 2'b11;
            sample();
            check("lock_gnt_hold", a_gnt, 2'b10);
            push_rd(1, 16'hBBBB);
        end
        tick();
        sample();
        check("lock_release", a_gnt, 2'b01);
        push_rd(0, 16'hAAAA);
        tick();
        a_req = 2'b10; a_lock = 2'b01;
        sample();
        check("lock_after", a_gnt, 2'b10);
        push_rd(1, 16'hBBBB);
        tick(); a_req = 2'b00; a_lock = 2'b00; sample();
        tick(); sample();

        // Write by master 0, snoop, then read-back by master 1.
        tick();
        a_req = 2'b01; a_wen = 2'b01; a_addr = {16'h0042, 16'h0042}; a_wdata = {16'h0000, 16'h1234};
        sample();
        check("wr_gnt", a_gnt, 2'b01);
        check("wr_wren", a_ram_wren, 1'b1);
        check("wr_addr", a_ram_addr, 16'h0042);
        check("wr_data", a_ram_data, 16'h1234);
        check("wr_snoop_pre", a_snoop_valid, 1'b0);
        tick();
        a_req = 2'b10; a_wen = 2'b00;
        sample();
        check("snoop_valid", a_snoop_valid, 1'b1);
        check("snoop_addr", a_snoop_addr, 16'h0042);
        check("snoop_data", a_snoop_data, 16'h1234);
        check("snoop_src", a_snoop_src, 1'b0);
        check("rb_gnt", a_gnt, 2'b10);
        check("rb_wren", a_ram_wren, 1'b0);
        push_rd(1, 16'h1234);
        tick();
        a_req = 2'b00;
        sample();
        check("snoop_one_cycle", a_snoop_valid, 1'b0);
        tick(); sample();

        // Reset the cycle after a read grant: the response is dropped.
        tick();
        a_prio = 1'b1; a_req = 2'b01; a_addr = {16'h0020, 16'h0010};
        sample();
        check("rst_rd_gnt", a_gnt, 2'b01);
        tick();
        a_req = 2'b00; reset = 1'b1;
        sample();
        check("rst_mid_gnt", a_gnt, 2'b00);
        tick();
        reset = 1'b0;
        sample();
        check("rst_mid_busy", a_busy, 1'b0);
        check("rst_mid_rvalid", a_rvalid, 2'b00);
        tick();
        a_req = 2'b11;
        sample();
        check("rst_ptr_zero", a_gnt, 2'b01);
        push_rd(0, 16'hAAAA);
        tick(); a_req = 2'b00; sample();
        tick(); sample();

        // Instance B: read latency READ_LAT+1 = 4.
        tick();
        b_req = 4'b0100; b_wen = 4'b0000;
        b_addr  = {16'h0033, 16'h0005, 16'h0011, 16'h0010};
        b_wdata = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        sample();
        check("b_rd_gnt", b_gnt, 4'b0100);
        check("b_rd_addr", b_ram_addr, 16'h0005);
        for (int k = 1; k <= 5; k++) begin
            tick();
            b_req = 4'b0000;
            sample();
            check("b_rvalid", b_rvalid, (k == 4) ? 4'b0100 : 4'b0000);
            check("b_busy", b_busy, (k <= 3) ? 1'b1 : 1'b0);
            if (k == 4) check("b_rdata", b_rdata, 16'h5A5A);
        end

        // Instance B: round-robin wrap from pointer 3, then fixed priority.
        tick();
        b_prio = 1'b1; b_wen = 4'b1111; b_req = 4'b1011;
        sample();
        check("b_rr_gnt0", b_gnt, 4'b1000);
        tick();
        sample();
        check("b_rr_gnt1", b_gnt, 4'b0001);
        check("b_snoop_valid", b_snoop_valid, 1'b1);
        check("b_snoop_src", b_snoop_src, 2'd3);
        check("b_snoop_addr", b_snoop_addr, 16'h0033);
        check("b_snoop_data", b_snoop_data, 16'hD003);
        tick();
        sample();
        check("b_rr_gnt2", b_gnt, 4'b0010);
        tick();
        b_prio = 1'b0; b_req = 4'b1010;
        sample();
        check("b_fix_gnt", b_gnt, 4'b0010);
        tick();
        b_req = 4'b0000;
        sample();
        check("b_fix_snoop_src", b_snoop_src, 2'd1);
        tick(); sample();

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ast_mem_arbiter_sv.md
Name: ast_mem_arbiter_sv

Overview:
- Parametrised N-master arbiter for the shared single-port system RAM.
- Replaces the two-way select between DMA and data cache that is keyed on the DMA busy flag.
- Supports fixed-priority or round-robin arbitration, locked bursts with a starvation cap, and read-return routing through a latency pipeline.
- Broadcasts a write snoop so caches can stay coherent with every other master's writes.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8); index 0 is highest fixed priority.
- DATAWIDTH, 16, RAM data width.
- ADDRWIDTH, 16, RAM address width.
- READ_LAT, 1, RAM read latency in cycles from address to q (1..4).
- LOCK_MAX, 16, maximum consecutive locked grants before forced release (>=1).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- prio_mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin; sampled every arbitration cycle.
- req  in  NUM_MASTERS  per-master access request.
- wen  in  NUM_MASTERS  per-master write enable; 1 = write, 0 = read.
- lock  in  NUM_MASTERS  per-master request to keep ownership after the current grant.
- addr  in  NUM_MASTERS*ADDRWIDTH  packed per-master addresses; master i occupies slice i.
- wdata  in  NUM_MASTERS*DATAWIDTH  packed per-master write data.
- gnt  out  NUM_MASTERS  one-hot, combinational; the access is accepted in this cycle.
- rvalid  out  NUM_MASTERS  one-hot, registered; rdata is valid for that master.
- rdata  out  DATAWIDTH  read data, shared by all masters.
- ram_addr  out  ADDRWIDTH  to the RAM address input.
- ram_data  out  DATAWIDTH  to the RAM data input.
- ram_wren  out  1  to the RAM write enable.
- ram_q  in  DATAWIDTH  from the RAM output.
- snoop_valid  out  1  registered; a write was committed in the previous cycle.
- snoop_addr  out  ADDRWIDTH  address of that write.
- snoop_data  out  DATAWIDTH  data of that write.
- snoop_src  out  $clog2(NUM_MASTERS)  index of the writing master.
- busy  out  1  high while any grant is issued or any read is in flight.

Behaviour:
- Reset values:
  - gnt, rvalid, ram_wren, snoop_valid, busy = 0.
  - rdata, snoop_* = 0.
  - Round-robin pointer = 0; lock owner cleared; lock counter = 0.
  - Read pipeline flushed. A reset mid-burst or mid-read drops all pending rvalid; no late response is delivered after reset.
- State machine:
  - ARB: no owner.
    - Winner in fixed mode = lowest-index asserted req.
    - Winner in round-robin mode = first asserted req at or after the pointer, wrapping modulo NUM_MASTERS.
    - gnt[winner] = 1 in the same cycle.
    - Pointer <= winner+1, wrapping from NUM_MASTERS-1 to 0.
    - If lock[winner] = 1 in that cycle: owner <= winner, counter <= 1, go to LOCKED.
  - LOCKED: only the owner can be granted; other reqs see gnt = 0.
    - Owner req=1 and lock=1 and counter < LOCK_MAX: grant, counter++.
    - Return to ARB on the next cycle if any of these hold in a cycle: owner lock=0, owner req=0, or counter == LOCK_MAX. A grant issued in that same cycle still completes.
    - Counter reaching LOCK_MAX forces a round-robin turn: the pointer is already past the owner.
- RAM drive:
  - When gnt[i] = 1: ram_addr = addr slice i, ram_data = wdata slice i, ram_wren = wen[i].
  - With no grant: ram_wren = 0, ram_addr and ram_data hold their last values.
- Read return:
  - A read grant pushes {valid, index} into a READ_LAT-deep shift register.
  - The stage-READ_LAT output is registered: rvalid[index] and rdata = ram_q appear READ_LAT+1 cycles after the grant. Total read latency is fixed at READ_LAT+1 regardless of arbitration.
  - Back-to-back reads, including from different masters, are fully pipelined: one grant per cycle.
- Snoop: a write grant registers snoop_valid = 1 with the write's addr, data and source index for exactly one cycle after the grant.
- Simultaneous events:
  - Master with req=0 and lock=1: lock is ignored.
  - Multiple reqs: exactly one gnt per cycle.
  - Read and write to the same address in consecutive cycles: RAM order is preserved (grant order).
- busy = (|gnt) | (any pipeline valid).

Decomposition:
- Package ast_mem_arb_pkg holds:
  - arb_state_t enum {ARB, LOCKED};
  - the priority-mode constants PRIO_FIXED and PRIO_RR;
  - the function rr_pick(req, ptr) returning the winner index and a found flag.
- One sub-module, ast_mem_arb_rdpipe_sv: parametrised shift register of {valid, index} by READ_LAT, with synchronous clear.

Test Plan (NUM_MASTERS=2, DATAWIDTH=16, READ_LAT=1, LOCK_MAX=4 unless stated):
- Fixed mode, req=2'b11, both reads at 0x0010 and 0x0020 (RAM preloaded 0xAAAA, 0xBBBB) -> gnt=01 at cycle 0, 10 at cycle 1; rvalid[0] with rdata=0xAAAA at cycle 2, rvalid[1] with 0xBBBB at cycle 3.
- Round-robin mode, both masters requesting continuously for 6 cycles -> gnt alternates 01,10,01,10,01,10.
- Master 1 holds lock with req, master 0 requesting -> master 1 granted 4 consecutive cycles, forced release, master 0 granted on the 5th.
- Master 0 writes 0x1234 to 0x0042 -> snoop_valid=1 one cycle later with snoop_addr=0x0042, snoop_data=0x1234, snoop_src=0; master 1 read of 0x0042 in the next cycle returns 0x1234.
- reset asserted the cycle after a read grant -> no rvalid, busy=0, pointer=0; with NUM_MASTERS=4 and READ_LAT=3, a read to 0x0005 returns after exactly 4 cycles.
